// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scanner: digit count, scan FSM
// encoding and the active-low hex segment table (bit0=a .. bit6=g, bit7=dp off).
package seg7_pkg;

    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic [0:0] {
        StBlank = 1'b0,
        StShow  = 1'b1
    } scan_state_e;

    // Index 0 is the rightmost entry; dp bit (bit7) is held high (off) throughout.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seven_segment_scanner_if.sv
// Load handshake and display outputs of the seven-segment scanner.
interface seven_segment_scanner_if;
    import seg7_pkg::*;

    logic                      load_valid;
    logic [4*NUM_DIGITS-1:0]   load_data;
    logic [NUM_DIGITS-1:0]     load_dp;
    logic                      load_ready;
    logic [7:0]                seg_n;
    logic [NUM_DIGITS-1:0]     dig_en_n;
    logic                      frame_start;

    modport master (
        output load_valid, load_data, load_dp,
        input  load_ready, seg_n, dig_en_n, frame_start
    );

    modport slave (
        input  load_valid, load_data, load_dp,
        output load_ready, seg_n, dig_en_n, frame_start
    );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern with decimal point.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] seg_n
);

    // Table lookup, then override the dp bit (active-low: lit drives 0).
    always_comb begin
        seg_n    = SEG_TABLE[hex];
        seg_n[7] = ~dp;
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner. Each digit slot opens with a
// blanking window to avoid ghosting, and new display words are double-buffered
// so they only take effect at a frame boundary.
module seven_segment_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    seven_segment_scanner_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);

    logic [CNT_W-1:0]          cnt_q;
    scan_state_e               state_q;
    logic [IDX_W-1:0]          idx_q;

    logic [7:0]                seg_n_q;
    logic [NUM_DIGITS-1:0]     dig_en_n_q;
    logic                      frame_start_q;

    logic                      pending_q;
    logic [4*NUM_DIGITS-1:0]   pend_data_q;
    logic [NUM_DIGITS-1:0]     pend_dp_q;
    logic [4*NUM_DIGITS-1:0]   act_data_q;
    logic [NUM_DIGITS-1:0]     act_dp_q;

    logic                      frame_bnd;
    logic                      accept;
    logic [3:0]                cur_nibble;
    logic                      cur_dp;
    logic [7:0]                dec_seg;

    // Frame boundary is the very first blank cycle of the digit-0 slot.
    always_comb begin
        frame_bnd  = (state_q == StBlank) && (cnt_q == '0) && (idx_q == '0);
        accept     = bus.load_valid && !pending_q;
        cur_nibble = act_data_q[{idx_q, 2'b00} +: 4];
        cur_dp     = act_dp_q[idx_q];
    end

    seg7_hex_decode u_decode (
        .hex   (cur_nibble),
        .dp    (cur_dp),
        .seg_n (dec_seg)
    );

    // Slot counter, scan FSM and digit index; outputs registered from current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            state_q       <= StBlank;
            idx_q         <= '0;
            seg_n_q       <= 8'hFF;
            dig_en_n_q    <= '1;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_bnd;
            if (state_q == StShow) begin
                seg_n_q    <= dec_seg;
                dig_en_n_q <= ~(NUM_DIGITS'(1) << idx_q);
            end else begin
                seg_n_q    <= 8'hFF;
                dig_en_n_q <= '1;
            end

            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            unique case (state_q)
                StBlank: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= StShow;
                    end
                end
                StShow: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= StBlank;
                        idx_q   <= idx_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // Double buffer: accept into pending, promote to active only at the frame boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= 1'b0;
            pend_data_q <= '0;
            pend_dp_q   <= '0;
            act_data_q  <= '0;
            act_dp_q    <= '0;
        end else begin
            if (frame_bnd && pending_q) begin
                act_data_q <= pend_data_q;
                act_dp_q   <= pend_dp_q;
            end
            // accept is blocked while pending, so it never races the promotion above.
            if (accept) begin
                pending_q   <= 1'b1;
                pend_data_q <= bus.load_data;
                pend_dp_q   <= bus.load_dp;
            end else if (frame_bnd) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.load_ready  = ~pending_q;
    assign bus.seg_n       = seg_n_q;
    assign bus.dig_en_n    = dig_en_n_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner with DIV=8, BLANK=2 (32-cycle frame).
module tb_seven_segment_scanner;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests = 0;
    int fails = 0;

    seven_segment_scanner_if bus ();

    seven_segment_scanner #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Active-high gfedcba patterns for 0..F, inverted for the active-low bus.
    function automatic logic [7:0] exp_seg(input logic [3:0] nib, input logic dp);
        logic [6:0] hi [16];
        hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return {~dp, ~hi[nib]};
    endfunction

    // Reference model: position within the timeline since reset release.
    bit          model_valid = 1'b0;
    int          pos = 0;
    bit          pend_m;
    logic [15:0] pend_data_m, act_data_m;
    logic [3:0]  pend_dp_m, act_dp_m;
    logic [7:0]  exp_sn;
    logic [3:0]  exp_dig;
    logic        exp_fs, exp_rdy;

    always @(posedge clk) begin
        if (rst) begin
            model_valid = 1'b1;
            pos         = 0;
            pend_m      = 1'b0;
            pend_data_m = '0;
            pend_dp_m   = '0;
            act_data_m  = '0;
            act_dp_m    = '0;
            exp_sn      = 8'hFF;
            exp_dig     = 4'hF;
            exp_fs      = 1'b0;
            exp_rdy     = 1'b1;
        end else begin
            int  p, slot, w;
            bit  acc;
            p    = pos;
            pos  = pos + 1;
            slot = (p / DIV) % 4;
            w    = p % DIV;
            acc  = bus.load_valid && !pend_m;
            if ((p % FRAME) == 0 && pend_m) begin
                act_data_m = pend_data_m;
                act_dp_m   = pend_dp_m;
                pend_m     = 1'b0;
            end
            if (acc) begin
                pend_m      = 1'b1;
                pend_data_m = bus.load_data;
                pend_dp_m   = bus.load_dp;
            end
            exp_fs  = ((p % FRAME) == 0);
            exp_rdy = !pend_m;
            if (w < BLANK) begin
                exp_sn  = 8'hFF;
                exp_dig = 4'hF;
            end else begin
                exp_sn  = exp_seg(act_data_m[slot*4 +: 4], act_dp_m[slot]);
                exp_dig = ~(4'(1) << slot);
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check("seg_n", 32'(bus.seg_n), 32'(exp_sn));
            check("dig_en_n", 32'(bus.dig_en_n), 32'(exp_dig));
            check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
            check("load_ready", 32'(bus.load_ready), 32'(exp_rdy));
        end
    end

    // Wait for the start of a fresh showing of digit d (bounded).
    task automatic seek_digit(input int d, output bit found);
        logic [3:0] tgt, prev;
        tgt   = ~(4'(1) << d);
        prev  = bus.dig_en_n;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (bus.dig_en_n == tgt && prev != tgt) found = 1'b1;
            else prev = bus.dig_en_n;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL seek_digit%0d: got timeout, expected digit enable", d);
        end
    endtask

    task automatic check_digit(input int d, input logic [7:0] want, input string name);
        bit found;
        seek_digit(d, found);
        if (found) check(name, 32'(bus.seg_n), 32'(want));
    endtask

    task automatic wait_frame();
        bit found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (bus.frame_start) found = 1'b1;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL wait_frame: got timeout, expected frame_start");
        end
    endtask

    task automatic offer(input logic [15:0] data, input logic [3:0] dp);
        bus.load_valid = 1'b1;
        bus.load_data  = data;
        bus.load_dp    = dp;
        @(negedge clk);
        bus.load_valid = 1'b0;
    endtask

    initial begin
        bit found;
        int fs_cnt, first_fs, second_fs;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.load_dp    = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_seg_n", 32'(bus.seg_n), 32'h FF);
        check("rst_dig_en_n", 32'(bus.dig_en_n), 32'hF);
        check("rst_load_ready", 32'(bus.load_ready), 32'h1);
        rst = 1'b0;
        fs_cnt = 0; first_fs = -1; second_fs = -1;
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (bus.frame_start) begin
                fs_cnt++;
                if (first_fs < 0) first_fs = i;
                else second_fs = i;
            end
        end
        check("idle_fs_count", 32'(fs_cnt), 32'd2);
        check("idle_fs_first", 32'(first_fs), 32'd1);
        check("idle_fs_gap", 32'(second_fs - first_fs), 32'd32);
        check_digit(0, 8'hC0, "idle_d0");
        check_digit(3, 8'hC0, "idle_d3");

        // Mid-frame load of 9876
        seek_digit(1, found);
        offer(16'h9876, 4'b0000);
        check("load_ready_fall", 32'(bus.load_ready), 32'h0);
        check_digit(2, 8'hC0, "old_frame_d2");
        check_digit(3, 8'hC0, "old_frame_d3");
        check_digit(0, 8'h82, "new_d0_6");
        check_digit(1, 8'hF8, "new_d1_7");
        check_digit(3, 8'h90, "new_d3_9");

        // Back-to-back loads: second is held off
        seek_digit(1, found);
        bus.load_valid = 1'b1;
        bus.load_data  = 16'h1111;
        bus.load_dp    = 4'b0000;
        @(negedge clk);
        check("b2b_ready_low", 32'(bus.load_ready), 32'h0);
        bus.load_data = 16'h2222;
        @(negedge clk);
        bus.load_valid = 1'b0;
        check_digit(0, 8'hF9, "b2b_d0_1");
        check_digit(2, 8'hF9, "b2b_d2_1");
        offer(16'h2222, 4'b0000);
        check_digit(0, 8'hA4, "reoffer_d0_2");
        check_digit(3, 8'hA4, "reoffer_d3_2");

        // Load in the frame_start cycle itself
        wait_frame();
        offer(16'h3333, 4'b0000);
        check_digit(0, 8'hA4, "bnd_load_old");
        check_digit(0, 8'hB0, "bnd_load_new");

        // Decimal point on digit 2
        offer(16'h0000, 4'b0100);
        check_digit(0, 8'hC0, "dp_d0");
        check_digit(2, 8'h40, "dp_d2");
        check_digit(3, 8'hC0, "dp_d3");

        // Reset during SHOW with a pending word
        seek_digit(1, found);
        offer(16'h8888, 4'b0000);
        seek_digit(2, found);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_seg_n", 32'(bus.seg_n), 32'hFF);
        check("midrst_dig_en_n", 32'(bus.dig_en_n), 32'hF);
        check("midrst_ready", 32'(bus.load_ready), 32'h1);
        rst = 1'b0;
        check_digit(0, 8'hC0, "postrst_d0");
        check_digit(3, 8'hC0, "postrst_d3");
        check_digit(0, 8'hC0, "postrst_lost");

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
